// File: rtl/capture_window_sched.sv
// Once-per-second capture window scheduler: after each second mark, waits start_dly
// cycles and then emits n_int windows of on_len cycles separated by off_len gaps.
module capture_window_sched #(
   parameter int CNT_W = 32,
   parameter int IDX_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             t1sec,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_wdata,
   output logic             win_en,
   output logic             win_start,
   output logic [IDX_W-1:0] win_idx,
   output logic             busy,
   output logic             overrun
);

   typedef enum logic [1:0] {IDLE, DELAY, ON, OFF} state_t;

   state_t           state, state_nxt;
   logic             sync_p0, sync_p1, sync_p2, tick;
   logic [CNT_W-1:0] sh_start_dly, sh_on_len, sh_off_len;
   logic [IDX_W-1:0] sh_n_int;
   logic [CNT_W-1:0] on_len, off_len;
   logic [IDX_W-1:0] n_int;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             start_nxt;

   // t1sec synchronizer; tick is registered so it lands one cycle after the third sampling edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
         tick    <= 1'b0;
      end else begin
         sync_p0 <= t1sec;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         tick    <= sync_p1 & ~sync_p2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_start_dly <= '0;
         sh_on_len    <= '0;
         sh_off_len   <= '0;
         sh_n_int     <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            2'd0:    sh_start_dly <= cfg_wdata;
            2'd1:    sh_on_len    <= cfg_wdata;
            2'd2:    sh_off_len   <= cfg_wdata;
            default: sh_n_int     <= cfg_wdata[IDX_W-1:0];
         endcase
      end
   end

   // start_dly is only consumed in the tick cycle, straight from the shadow copy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         on_len  <= '0;
         off_len <= '0;
         n_int   <= '0;
      end else if (tick) begin
         on_len  <= sh_on_len;
         off_len <= sh_off_len;
         n_int   <= sh_n_int;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = win_idx;
      start_nxt = 1'b0;
      if (tick) begin
         idx_nxt = '0;
         if (sh_on_len == '0 || sh_n_int == '0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end else if (sh_start_dly == '0) begin
            state_nxt = ON;
            cnt_nxt   = sh_on_len - CNT_W'(1);
            start_nxt = 1'b1;
         end else begin
            state_nxt = DELAY;
            cnt_nxt   = sh_start_dly - CNT_W'(1);
         end
      end else begin
         case (state)
            IDLE: ;
            DELAY: begin
               if (cnt == '0) begin
                  state_nxt = ON;
                  cnt_nxt   = on_len - CNT_W'(1);
                  start_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            ON: begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - CNT_W'(1);
               end else if (win_idx == n_int - IDX_W'(1)) begin
                  state_nxt = IDLE;
               end else if (off_len == '0) begin
                  cnt_nxt   = on_len - CNT_W'(1);
                  idx_nxt   = win_idx + IDX_W'(1);
                  start_nxt = 1'b1;
               end else begin
                  state_nxt = OFF;
                  cnt_nxt   = off_len - CNT_W'(1);
               end
            end
            OFF: begin
               if (cnt == '0) begin
                  state_nxt = ON;
                  cnt_nxt   = on_len - CNT_W'(1);
                  idx_nxt   = win_idx + IDX_W'(1);
                  start_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // outputs are registered from next-state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         win_idx   <= '0;
         win_start <= 1'b0;
         win_en    <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         win_idx   <= idx_nxt;
         win_start <= start_nxt;
         win_en    <= (state_nxt == ON);
         busy      <= (state_nxt != IDLE);
         if (tick && busy)
            overrun <= 1'b1;
         else if (cfg_we)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_capture_window_sched.sv
// Directed bench for capture_window_sched: schedule timing, gaps, disable, overrun,
// shadow isolation and mid-window reset.
module tb_capture_window_sched;

   logic        clk;
   logic        rst_n;
   logic        t1sec;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic        win_en;
   logic        win_start;
   logic [15:0] win_idx;
   logic        busy;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;

   capture_window_sched #(.CNT_W(32), .IDX_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .t1sec     (t1sec),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .win_en    (win_en),
      .win_start (win_start),
      .win_idx   (win_idx),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      step();
      cfg_we    = 1'b0;
   endtask

   task automatic cfg(input int sd, input int on, input int off, input int n);
      wr(2'd0, sd);
      wr(2'd1, on);
      wr(2'd2, off);
      wr(2'd3, n);
   endtask

   // leaves the bench sitting in the tick cycle T
   task automatic pulse();
      cfg_we = 1'b0;
      t1sec  = 1'b1;
      repeat (3) step();
      t1sec  = 1'b0;
   endtask

   // checks cycles T+1..T+ncyc against the window formula; optional write in cycle T+wr_k
   task automatic check_sched(input int sd, input int on, input int off, input int n,
                              input int ncyc, input int wr_k,
                              input logic [1:0] wa, input logic [31:0] wd);
      int   per, last, rel;
      logic act, e_en, e_st, e_busy;
      per  = on + off;
      act  = (on != 0) && (n != 0);
      last = act ? (sd + (n - 1) * per + on) : 0;
      for (int k = 1; k <= ncyc; k++) begin
         step();
         cfg_we    = (k == wr_k);
         cfg_addr  = wa;
         cfg_wdata = wd;
         rel    = k - 1 - sd;
         e_en   = act && rel >= 0 && (rel / per) < n && (rel % per) < on;
         e_st   = e_en && (rel % per) == 0;
         e_busy = act && k <= last;
         check($sformatf("win_en@T+%0d", k), win_en, e_en);
         check($sformatf("win_start@T+%0d", k), win_start, e_st);
         check($sformatf("busy@T+%0d", k), busy, e_busy);
         if (e_en)
            check($sformatf("win_idx@T+%0d", k), win_idx, rel / per);
      end
      cfg_we = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      t1sec     = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = 2'd0;
      cfg_wdata = '0;
      repeat (3) step();
      check("rst_win_en", win_en, 0);
      check("rst_win_start", win_start, 0);
      check("rst_win_idx", win_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      step();

      // basic schedule
      cfg(5, 4, 3, 3);
      pulse();
      check("basic_busy@T", busy, 0);
      check_sched(5, 4, 3, 3, 27, 0, 2'd0, 0);
      check("basic_overrun", overrun, 0);

      // back-to-back windows
      cfg(0, 2, 0, 4);
      pulse();
      check_sched(0, 2, 0, 4, 11, 0, 2'd0, 0);

      // on_len = 1
      cfg(3, 1, 2, 2);
      pulse();
      check_sched(3, 1, 2, 2, 10, 0, 2'd0, 0);

      // disabled by n_int = 0, then by on_len = 0
      cfg(0, 4, 0, 0);
      pulse();
      check_sched(0, 4, 0, 0, 8, 0, 2'd0, 0);
      cfg(0, 0, 0, 2);
      pulse();
      check_sched(0, 0, 0, 2, 8, 0, 2'd0, 0);

      // overrun: second mark arrives 100 cycles into a 1000-cycle window
      cfg(0, 1000, 0, 1);
      pulse();
      repeat (100) step();
      check("ovr_first_en", win_en, 1);
      pulse();
      check("ovr_before_set", overrun, 0);
      check_sched(0, 1000, 0, 1, 1003, 0, 2'd0, 0);
      check("ovr_set", overrun, 1);
      wr(2'd2, 0);
      check("ovr_clr", overrun, 0);

      // shadow isolation: mid-schedule write held off, tick-cycle write held off a second
      cfg(2, 4, 3, 3);
      pulse();
      check_sched(2, 4, 3, 3, 26, 4, 2'd1, 9);
      pulse();
      cfg_we    = 1'b1;
      cfg_addr  = 2'd1;
      cfg_wdata = 2;
      check_sched(2, 9, 3, 3, 41, 0, 2'd0, 0);
      pulse();
      check_sched(2, 2, 3, 3, 20, 0, 2'd0, 0);

      // reset in the middle of a window
      cfg(0, 10, 0, 1);
      pulse();
      repeat (3) step();
      check("rstmid_en_before", win_en, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rstmid_win_en", win_en, 0);
      check("rstmid_win_start", win_start, 0);
      check("rstmid_win_idx", win_idx, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_overrun", overrun, 0);
      for (int k = 0; k < 12; k++) begin
         step();
         check($sformatf("rstmid_idle_busy%0d", k), busy, 0);
         check($sformatf("rstmid_idle_en%0d", k), win_en, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
